imem_loadable: RTL and testbench

Parametrised, runtime-loadable instruction memory that replaces the fixed combinational program ROM on the RISC-V core's fetch port. A loader (UART/JTAG bridge or testbench) writes the program into synchronous RAM before execution. The block then serves registered single-cycle fetches to the core. It detects the custom HALT word and freezes fetch, and it can be reloaded and restarted without a full reset.

---
 rtl/imem_loadable.sv | 143 ++++++++++++++
 tb/tb_imem_loadable.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loadable.sv
// imem_loadable: runtime-loadable instruction memory for the core fetch port.
// A loader writes the program during LOAD. RUN serves registered single-cycle
// fetches. Fetching HALT_WORD freezes fetch until the memory is reloaded or
// restarted.
// Optional feature: define IMEM_BOOT_CLEAR_EN to add a CLEAR walk after reset.
// The walk fills the memory with NOP_WORD before LOAD.
module imem_loadable #(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = $clog2(DEPTH),
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF,
  parameter logic [31:0] NOP_WORD  = 32'h0000_0013
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          load_we_i,
  input  logic [AW-1:0] load_addr_i,
  input  logic [31:0]   load_data_i,
  input  logic          load_done_i,
  output logic          load_ready_o,
  input  logic          ird_i,
  input  logic [31:0]   iaddr_i,
  output logic          accept_o,
  output logic [31:0]   irdata_o,
  output logic          irvalid_o,
  output logic          halted_o,
  output logic          addr_err_o,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_HALT  = 2'd3
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [31:0]   r_mem [DEPTH];
  logic [31:0]   r_irdata;
  logic          r_irvalid;
  logic          r_addr_err;

  logic          w_we;
  logic [AW-1:0] w_waddr;
  logic [31:0]   w_wdata;
  logic          w_load_ok;
  logic          w_fetch;
  logic          w_in_range;
  logic          w_misal;
  logic [AW-1:0] w_ridx;
  logic [AW-1:0] w_clr_idx;
  logic          w_clr_last;

`ifdef IMEM_BOOT_CLEAR_EN
  localparam state_t RESET_STATE = S_CLEAR;
  logic [AW-1:0] r_clr_idx;

  // Clear-walk index; reset restarts the walk at word 0.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i)                r_clr_idx <= '0;
    else if (r_state == S_CLEAR) r_clr_idx <= r_clr_idx + 1'b1;
  end

  assign w_clr_idx  = r_clr_idx;
  assign w_clr_last = (r_clr_idx == AW'(DEPTH - 1));
`else
  localparam state_t RESET_STATE = S_LOAD;
  assign w_clr_idx  = '0;
  assign w_clr_last = 1'b1;
`endif

  assign w_load_ok  = (32'(load_addr_i) < DEPTH);
  assign w_in_range = (iaddr_i[31:2] < 30'(DEPTH));
  assign w_misal    = |iaddr_i[1:0];
  assign w_ridx     = iaddr_i[AW+1:2];
  assign w_fetch    = (r_state == S_RUN) && ird_i;

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) r_state <= RESET_STATE;
    else         r_state <= w_next;
  end

  // Next state and the single memory write port.
  // HALT is entered from the registered fetch result. A fetch sampled on that
  // same edge is still served because the state is RUN until the edge.
  always_comb begin
    w_next  = r_state;
    w_we    = 1'b0;
    w_waddr = load_addr_i;
    w_wdata = load_data_i;
    case (r_state)
      S_CLEAR: begin
        w_we    = 1'b1;
        w_waddr = w_clr_idx;
        w_wdata = NOP_WORD;
        if (w_clr_last) w_next = S_LOAD;
      end
      S_LOAD: begin
        w_we = load_we_i && w_load_ok;
        if (load_done_i) w_next = S_RUN;
      end
      S_RUN: begin
        if (r_irvalid && (r_irdata == HALT_WORD)) w_next = S_HALT;
      end
      S_HALT: begin
        w_we = load_we_i && w_load_ok;
        if (load_done_i)    w_next = S_RUN;
        else if (load_we_i) w_next = S_LOAD;
      end
      default: w_next = RESET_STATE;
    endcase
    if (reset_i) w_we = 1'b0;
  end

  // Program storage; contents survive reset.
  always_ff @(posedge clk_i) begin
    if (w_we) r_mem[w_waddr] <= w_wdata;
  end

  // Registered fetch path: data, valid strobe and address-error pulse.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_irdata   <= NOP_WORD;
      r_irvalid  <= 1'b0;
      r_addr_err <= 1'b0;
    end else begin
      r_irvalid  <= w_fetch;
      r_addr_err <= w_fetch && (!w_in_range || w_misal);
      if (w_fetch) r_irdata <= w_in_range ? r_mem[w_ridx] : NOP_WORD;
    end
  end

  assign irdata_o     = r_irdata;
  assign irvalid_o    = r_irvalid;
  assign addr_err_o   = r_addr_err;
  assign halted_o     = (r_state == S_HALT);
  assign accept_o     = (r_state == S_RUN);
  assign load_ready_o = (r_state == S_LOAD);
  assign state_o      = r_state;

endmodule

// File: tb/tb_imem_loadable.sv
// Testbench for imem_loadable (DEPTH=16).
// It checks directed fetch, halt, reload and reset scenarios, plus random
// fetches, against a word-array reference model.
module tb_imem_loadable;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned AW    = 4;
  localparam logic [31:0] HALT  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP   = 32'h0000_0013;
`ifdef IMEM_BOOT_CLEAR_EN
  localparam logic [31:0] RST_STATE = 32'd0;
  localparam logic [31:0] RST_READY = 32'd0;
`else
  localparam logic [31:0] RST_STATE = 32'd1;
  localparam logic [31:0] RST_READY = 32'd1;
`endif

  logic          clk = 1'b0;
  logic          reset_i;
  logic          load_we_i;
  logic [AW-1:0] load_addr_i;
  logic [31:0]   load_data_i;
  logic          load_done_i;
  logic          load_ready_o;
  logic          ird_i;
  logic [31:0]   iaddr_i;
  logic          accept_o;
  logic [31:0]   irdata_o;
  logic          irvalid_o;
  logic          halted_o;
  logic          addr_err_o;
  logic [1:0]    state_o;

  imem_loadable #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk_i       (clk),
    .reset_i     (reset_i),
    .load_we_i   (load_we_i),
    .load_addr_i (load_addr_i),
    .load_data_i (load_data_i),
    .load_done_i (load_done_i),
    .load_ready_o(load_ready_o),
    .ird_i       (ird_i),
    .iaddr_i     (iaddr_i),
    .accept_o    (accept_o),
    .irdata_o    (irdata_o),
    .irvalid_o   (irvalid_o),
    .halted_o    (halted_o),
    .addr_err_o  (addr_err_o),
    .state_o     (state_o)
  );

  always #5 clk = ~clk;

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;
  logic [31:0] m_mem [DEPTH];
  logic [31:0] m_last;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference fetch: word index = byte address / 4. An index past the end
  // returns NOP. An error is flagged when out of range or not word aligned.
  task automatic model_fetch(input logic [31:0] a, output logic [31:0] d, output logic e);
    logic [31:0] idx;
    idx = a / 4;
    d   = (idx < DEPTH) ? m_mem[idx] : NOP;
    e   = (idx >= DEPTH) || ((a % 4) != 0);
  endtask

  task automatic do_fetch(input logic [31:0] a, input string tag);
    logic [31:0] d;
    logic        e;
    ird_i   = 1'b1;
    iaddr_i = a;
    step();
    model_fetch(a, d, e);
    chk({tag, "_data"}, irdata_o, d);
    chk({tag, "_valid"}, 32'(irvalid_o), 32'd1);
    chk({tag, "_err"}, 32'(addr_err_o), 32'(e));
    m_last = d;
  endtask

  task automatic do_idle(input string tag);
    ird_i = 1'b0;
    step();
    chk({tag, "_valid"}, 32'(irvalid_o), 32'd0);
    chk({tag, "_err"}, 32'(addr_err_o), 32'd0);
    chk({tag, "_hold"}, irdata_o, m_last);
  endtask

  task automatic do_load(input logic [AW-1:0] a, input logic [31:0] d);
    load_we_i   = 1'b1;
    load_addr_i = a;
    load_data_i = d;
    step();
    load_we_i = 1'b0;
    m_mem[a]  = d;
  endtask

  task automatic pulse_done();
    load_done_i = 1'b1;
    step();
    load_done_i = 1'b0;
  endtask

  function automatic logic [31:0] rnd_word();
    logic [31:0] w;
    w = $urandom();
    if (w == HALT) w = 32'h0;
    return w;
  endfunction

  initial begin
    logic [31:0] a;
    logic [31:0] w;
    int unsigned r;

    reset_i = 1'b1; load_we_i = 1'b0; load_addr_i = '0; load_data_i = '0;
    load_done_i = 1'b0; ird_i = 1'b1; iaddr_i = '0;
    m_last = NOP;
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;

    // Reset values (a fetch request is held high throughout).
    repeat (3) step();
    chk("rst_state", 32'(state_o), RST_STATE);
    chk("rst_irdata", irdata_o, NOP);
    chk("rst_irvalid", 32'(irvalid_o), 32'd0);
    chk("rst_halted", 32'(halted_o), 32'd0);
    chk("rst_err", 32'(addr_err_o), 32'd0);
    chk("rst_ready", 32'(load_ready_o), RST_READY);
    chk("rst_accept", 32'(accept_o), 32'd0);
    reset_i = 1'b0;

`ifdef IMEM_BOOT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) begin
      chk("clear_state", 32'(state_o), 32'd0);
      chk("clear_ready", 32'(load_ready_o), 32'd0);
      step();
    end
`endif
    chk("load_state", 32'(state_o), 32'd1);
    chk("load_ready", 32'(load_ready_o), 32'd1);
    step();
    chk("load_fetch_valid", 32'(irvalid_o), 32'd0);
    chk("load_fetch_data", irdata_o, NOP);
    ird_i = 1'b0;

    // Program load; the last word shares its cycle with load_done.
    do_load(4'd0, 32'h0240_0493);
    do_load(4'd1, 32'h0010_0293);
    do_load(4'd2, 32'h0054_2023);
    do_load(4'd3, HALT);
    for (int i = 4; i < DEPTH - 1; i++) do_load(AW'(i), rnd_word());
    w = rnd_word();
    load_we_i = 1'b1; load_addr_i = AW'(DEPTH - 1); load_data_i = w; load_done_i = 1'b1;
    step();
    load_we_i = 1'b0; load_done_i = 1'b0;
    m_mem[DEPTH-1] = w;
    chk("run_state", 32'(state_o), 32'd2);
    chk("run_accept", 32'(accept_o), 32'd1);
    chk("run_ready", 32'(load_ready_o), 32'd0);

    // A loader write in RUN is dropped.
    load_we_i = 1'b1; load_addr_i = '0; load_data_i = 32'hDEAD_BEEF;
    step();
    load_we_i = 1'b0;

    do_fetch(32'd0, "f0");
    do_fetch(32'd4, "f4");
    do_fetch(32'd8, "f8");
    do_idle("idle0");
    do_fetch(32'd60, "f60");
    do_fetch(32'h40, "oor");
    do_idle("oor_idle");
    do_fetch(32'h06, "misal");
    do_idle("misal_idle");

    // Random fetches; the HALT word (index 3) is avoided here.
    for (int k = 0; k < 80; k++) begin
      r = $urandom_range(0, 9);
      if (r < 6) begin
        a = 32'($urandom_range(0, 63));
        if ((a / 4) == 3) a = a ^ 32'd4;
        do_fetch(a, "rnd_in");
      end else if (r < 8) begin
        a = $urandom();
        if (a < 64) a = a + 32'd64;
        do_fetch(a, "rnd_oor");
      end else begin
        do_idle("rnd_idle");
      end
    end
    do_idle("rnd_end");

    // HALT entry, then requests are refused.
    do_fetch(32'd12, "halt");
    do_idle("halt_idle");
    chk("halt_state", 32'(state_o), 32'd3);
    chk("halt_flag", 32'(halted_o), 32'd1);
    chk("halt_accept", 32'(accept_o), 32'd0);
    ird_i = 1'b1; iaddr_i = 32'd0;
    step();
    chk("halt_req_valid", 32'(irvalid_o), 32'd0);
    chk("halt_req_data", irdata_o, HALT);
    ird_i = 1'b0;

    // Restart with current contents.
    pulse_done();
    chk("restart_state", 32'(state_o), 32'd2);
    chk("restart_halted", 32'(halted_o), 32'd0);
    do_fetch(32'd0, "restart_f0");

    // A fetch sampled on the halt-transition edge still completes.
    do_fetch(32'd12, "halt2");
    chk("bnd_accept", 32'(accept_o), 32'd1);
    do_fetch(32'd12, "bnd");
    chk("bnd_state", 32'(state_o), 32'd3);
    chk("bnd_halted", 32'(halted_o), 32'd1);
    ird_i = 1'b0;

    // A write from HALT goes to LOAD; the word is patched, then RUN.
    do_load(4'd3, NOP);
    chk("rl_state", 32'(state_o), 32'd1);
    chk("rl_halted", 32'(halted_o), 32'd0);
    chk("rl_ready", 32'(load_ready_o), 32'd1);
    do_load(4'd7, HALT);
    pulse_done();
    chk("rl_run", 32'(state_o), 32'd2);
    do_fetch(32'd12, "rl_f12");
    do_idle("rl_idle");
    chk("rl_still_run", 32'(state_o), 32'd2);
    chk("rl_not_halted", 32'(halted_o), 32'd0);

    // Halt again, then assert reset between edges.
    do_fetch(32'd28, "h7");
    do_fetch(32'd0, "h7_bnd");
    chk("pre_rst_halted", 32'(halted_o), 32'd1);
    #2;
    reset_i = 1'b1;
    #1;
    chk("arst_valid", 32'(irvalid_o), 32'd0);
    chk("arst_halted", 32'(halted_o), 32'd0);
    chk("arst_irdata", irdata_o, NOP);
    chk("arst_state", 32'(state_o), RST_STATE);
    ird_i = 1'b0;
    m_last = NOP;
    step();
    step();
    reset_i = 1'b0;
`ifdef IMEM_BOOT_CLEAR_EN
    for (int i = 0; i < DEPTH; i++) m_mem[i] = NOP;
    repeat (DEPTH) step();
`endif
    chk("post_rst_load", 32'(state_o), 32'd1);
    pulse_done();
    chk("post_rst_run", 32'(state_o), 32'd2);
    for (int i = 0; i < DEPTH; i++) begin
      if (i != 7) do_fetch(32'(i * 4), "post_rst_f");
    end
    do_fetch(32'd28, "post_rst_f7");
    do_idle("post_rst_idle");
    chk("post_rst_final_state", 32'(state_o), (m_mem[7] == HALT) ? 32'd3 : 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
